t05_cb_header_synth: RTL and testbench
======================================

T05_CB_HEADER_SYNTH -- requirements
Module: t05_cb_header_synth

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 max_index  input  7  root node index of the Huffman tree; sampled in INIT only.
REQ-005 h_element  input  71  node read combinationally at curr_index: [70:64] ignored, [63:55] left child, [54:46] right child, [45:0] weight (ignored).
REQ-006 Child field layout: bit 8 = 1 means internal node with index in [6:0]; bit 8 = 0 means leaf with character in [7:0].
REQ-007 curr_index  output  7  node address requested from tree memory.
REQ-008 curr_path  output  128  current root-to-node path: bit i = branch at depth i (0 = left, 1 = right); sentinel 1 at bit [depth]; all higher bits 0.
REQ-009 curr_state  output  3  encoding LEFT=0, RIGHT=1, TRACK=2, BACKTRACK=3, FINISH=4, INIT=5.
REQ-010 char_path  output  128  codeword of the last found character, same format as curr_path.
REQ-011 char_index  output  8  last found character.
REQ-012 char_found  output  1  one-cycle pulse when char_path/char_index are updated.
REQ-013 finished  output  4  4'd1 while in FINISH, else 4'd0.
REQ-014 least1, least2  output  9  root left and right child fields, captured in INIT.
REQ-015 header  output  10  registered header record stream.

Function
REQ-016 INIT: capture root = max_index, curr_index = max_index, curr_path = 128'd1, least1/least2 = root child fields; next state is LEFT.
REQ-017 LEFT, internal left child: append 0 to curr_path, set curr_index to child index, stay in LEFT.
REQ-018 LEFT, leaf left child: char_index = char, char_path = curr_path with 0 appended, pulse char_found; next state is RIGHT at the same node.
REQ-019 RIGHT, internal right child: append 1 to curr_path, set curr_index to child index; next state is LEFT.
REQ-020 RIGHT, leaf right child: emit the character with 1 appended (as in REQ-018); next state is BACKTRACK.
REQ-021 BACKTRACK removes one path bit per cycle.
REQ-022 BACKTRACK, removed bit = 1: stay in BACKTRACK.
REQ-023 BACKTRACK, removed bit = 0: set curr_index = root, track position = 0; next state is TRACK.
REQ-024 BACKTRACK, depth reaches 0 with no 0 bit found: next state is FINISH.
REQ-025 TRACK, track position < depth: follow path bit (left or right child index) and increment position; one cycle per level.
REQ-026 TRACK, track position == depth: next state is RIGHT.
REQ-027 FINISH holds until reset; curr_index and the path registers are frozen.
REQ-028 Maximum depth is 127; a descent beyond this goes to FINISH.
REQ-029 header: 10'd0 by default; in the cycle after each char_found, header = {2'b11, char_index} for exactly one cycle.

Reset
REQ-030 While rst = 0, all state is cleared immediately: state = INIT, curr_index = 0, curr_path and char_path = 128'd1, char_index = 0, char_found = 0, finished = 0, least1/least2 = 0, header = 0.
REQ-031 Asserting reset mid-traversal aborts the traversal; the traversal restarts from INIT on the first clock edge after release.

Configuration
REQ-032 Macro T05_CB_HEADER_ROOT_EN defined: in the cycle after INIT, header = {2'b10, least1[8], least2[8], 6'd0} for one cycle.
REQ-033 Macro T05_CB_HEADER_ROOT_EN undefined: no root record is emitted; all other behaviour is identical.

Verification
REQ-034 Test tree (root 8): 8=(i6,i7), 6=(i3,i4), 3=(i0,'A'), 0=('C','B'), 4=('F',i1), 1=('D','E'), 7=('J',i5), 5=('G',i2), 2=('H','I'); reset, then serve h_element = tree[curr_index] -> char_found order C,B,A,F,D,E,J,G,H,I, then finished = 1 within 100 cycles.
REQ-035 Same tree -> char_path: C = 128'h10, B = 128'h18, A = 128'hC, J = 128'h5, I = 128'h1F.
REQ-036 Same tree -> header = {2'b11, 8'd67} in the cycle after the C pulse; least1 = 9'h106, least2 = 9'h107.
REQ-037 Single-node tree 0=('X','Y'), max_index 0 -> X with path 128'h2, Y with path 128'h3, then FINISH.
REQ-038 Reset asserted while in TRACK -> outputs take their REQ-030 values immediately; after release the full character sequence of REQ-034 repeats.
REQ-039 With T05_CB_HEADER_ROOT_EN defined on the test tree -> header = 10'b10_1_1_000000 exactly once after INIT.

Source files
------------

// File: rtl/t05_cb_header_synth.sv
// -----------------------------------------------------------------------------
// t05_cb_header_synth
//
// Purpose:
//   Walks a Huffman tree held in an external node memory. It emits one
//   (character, codeword) pair per leaf, in depth-first left-to-right order.
//   It also produces a registered header record stream: one {2'b11, char}
//   word in the cycle after every char_found pulse.
//
//   The walk keeps only the root-to-node path. It does not keep a stack of
//   node indices. When the walk backtracks to a pending right branch, it
//   re-descends from the root (TRACK) by following the stored path bits.
//
// Optional feature:
//   T05_CB_HEADER_ROOT_EN -- when defined, emits one extra root record
//   {2'b10, least1[8], least2[8], 6'd0} right after INIT.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   max_index   root node index (sampled in INIT)
//   h_element   node at curr_index: [63:55] left child, [54:46] right child
//   curr_index  node address presented to the tree memory
//   curr_path   current path, sentinel 1 at bit [depth]
//   curr_state  LEFT=0 RIGHT=1 TRACK=2 BACKTRACK=3 FINISH=4 INIT=5
//   char_path   codeword of the last found character
//   char_index  last found character
//   char_found  one-cycle pulse when char_path/char_index are updated
//   finished    4'd1 while in FINISH
//   least1/2    root left/right child fields
//   header      header record stream
// -----------------------------------------------------------------------------
module t05_cb_header_synth (
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   max_index,
  input  logic [70:0]  h_element,
  output logic [6:0]   curr_index,
  output logic [127:0] curr_path,
  output logic [2:0]   curr_state,
  output logic [127:0] char_path,
  output logic [7:0]   char_index,
  output logic         char_found,
  output logic [3:0]   finished,
  output logic [8:0]   least1,
  output logic [8:0]   least2,
  output logic [9:0]   header
);

  typedef enum logic [2:0] {
    S_LEFT   = 3'd0,
    S_RIGHT  = 3'd1,
    S_TRACK  = 3'd2,
    S_BACK   = 3'd3,
    S_FINISH = 3'd4,
    S_INIT   = 3'd5
  } state_t;

  state_t         state_q;
  logic [6:0]     root_q;
  logic [6:0]     curr_index_q;
  logic [127:0]   curr_path_q;
  logic [6:0]     depth_q;
  logic [6:0]     track_pos_q;
  logic           root_pending_q;
  logic [127:0]   char_path_q;
  logic [7:0]     char_index_q;
  logic           char_found_q;
  logic [3:0]     finished_q;
  logic [8:0]     least1_q;
  logic [8:0]     least2_q;
  logic [9:0]     header_q;

  // Child fields of the node currently addressed.
  logic [8:0] left_fld;
  logic [8:0] right_fld;
  assign left_fld  = h_element[63:55];
  assign right_fld = h_element[54:46];

  // The upper tag bits and the weight field do not affect the walk.
  logic unused_fields;
  assign unused_fields = ^{h_element[70:64], h_element[45:0]};

  // Path edits relative to the sentinel at bit [depth].
  // An append overwrites the sentinel with the branch bit and moves the
  // sentinel one place up. A pop clears the sentinel and turns the bit
  // below it into the new sentinel.
  logic [127:0] bit_at_depth;
  logic [127:0] path_app0_d;
  logic [127:0] path_app1_d;
  logic [127:0] path_pop_d;
  logic         popped_bit;
  logic         track_bit;

  assign bit_at_depth = 128'd1 << depth_q;
  assign path_app0_d  = (curr_path_q & ~bit_at_depth) | (bit_at_depth << 1);
  assign path_app1_d  = curr_path_q | (bit_at_depth << 1);
  assign path_pop_d   = (curr_path_q & ~bit_at_depth) | (bit_at_depth >> 1);
  assign popped_bit   = |(curr_path_q & (bit_at_depth >> 1));
  assign track_bit    = |(curr_path_q & (128'd1 << track_pos_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_INIT;
      root_q         <= 7'd0;
      curr_index_q   <= 7'd0;
      curr_path_q    <= 128'd1;
      depth_q        <= 7'd0;
      track_pos_q    <= 7'd0;
      root_pending_q <= 1'b0;
      char_path_q    <= 128'd1;
      char_index_q   <= 8'd0;
      char_found_q   <= 1'b0;
      finished_q     <= 4'd0;
      least1_q       <= 9'd0;
      least2_q       <= 9'd0;
      header_q       <= 10'd0;
    end else begin
      char_found_q <= 1'b0;
      header_q     <= char_found_q ? {2'b11, char_index_q} : 10'd0;

      case (state_q)
        S_INIT: begin
          root_q         <= max_index;
          curr_index_q   <= max_index;
          curr_path_q    <= 128'd1;
          depth_q        <= 7'd0;
          track_pos_q    <= 7'd0;
          root_pending_q <= 1'b1;
          state_q        <= S_LEFT;
        end

        S_LEFT: begin
          // During INIT the memory is still addressed by the reset index.
          // The root children are therefore latched on the first LEFT cycle,
          // which is the first cycle that the root is actually presented.
          if (root_pending_q) begin
            least1_q       <= left_fld;
            least2_q       <= right_fld;
            root_pending_q <= 1'b0;
`ifdef T05_CB_HEADER_ROOT_EN
            header_q       <= {2'b10, left_fld[8], right_fld[8], 6'd0};
`endif
          end
          if (depth_q == 7'd127) begin
            // The path register cannot hold a deeper codeword.
            state_q    <= S_FINISH;
            finished_q <= 4'd1;
          end else if (left_fld[8]) begin
            curr_path_q  <= path_app0_d;
            curr_index_q <= left_fld[6:0];
            depth_q      <= depth_q + 7'd1;
          end else begin
            char_index_q <= left_fld[7:0];
            char_path_q  <= path_app0_d;
            char_found_q <= 1'b1;
            state_q      <= S_RIGHT;
          end
        end

        S_RIGHT: begin
          if (depth_q == 7'd127) begin
            state_q    <= S_FINISH;
            finished_q <= 4'd1;
          end else if (right_fld[8]) begin
            curr_path_q  <= path_app1_d;
            curr_index_q <= right_fld[6:0];
            depth_q      <= depth_q + 7'd1;
            state_q      <= S_LEFT;
          end else begin
            char_index_q <= right_fld[7:0];
            char_path_q  <= path_app1_d;
            char_found_q <= 1'b1;
            state_q      <= S_BACK;
          end
        end

        S_BACK: begin
          if (depth_q == 7'd0) begin
            // The root's right child was a leaf, so nothing is left to visit.
            state_q    <= S_FINISH;
            finished_q <= 4'd1;
          end else begin
            curr_path_q <= path_pop_d;
            depth_q     <= depth_q - 7'd1;
            if (!popped_bit) begin
              // A left branch was undone. Its sibling (right) subtree is
              // still pending, so re-descend from the root to that node.
              curr_index_q <= root_q;
              track_pos_q  <= 7'd0;
              state_q      <= S_TRACK;
            end else if (depth_q == 7'd1) begin
              state_q    <= S_FINISH;
              finished_q <= 4'd1;
            end
          end
        end

        S_TRACK: begin
          if (track_pos_q == depth_q) begin
            state_q <= S_RIGHT;
          end else begin
            curr_index_q <= track_bit ? right_fld[6:0] : left_fld[6:0];
            track_pos_q  <= track_pos_q + 7'd1;
          end
        end

        S_FINISH: begin
          finished_q <= 4'd1;
        end

        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign curr_index = curr_index_q;
  assign curr_path  = curr_path_q;
  assign curr_state = state_q;
  assign char_path  = char_path_q;
  assign char_index = char_index_q;
  assign char_found = char_found_q;
  assign finished   = finished_q;
  assign least1     = least1_q;
  assign least2     = least2_q;
  assign header     = header_q;

endmodule

// File: tb/tb_t05_cb_header_synth.sv
// -----------------------------------------------------------------------------
// tb_t05_cb_header_synth
//
// Directed bench for t05_cb_header_synth. It serves h_element from a small
// tree array and collects every character pulse. It then compares the
// collected results against hand-derived codewords and header records.
// Also covers T05_CB_HEADER_ROOT_EN when the macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_t05_cb_header_synth;

  logic         clk;
  logic         rst;
  logic [6:0]   max_index;
  logic [70:0]  h_element;
  logic [6:0]   curr_index;
  logic [127:0] curr_path;
  logic [2:0]   curr_state;
  logic [127:0] char_path;
  logic [7:0]   char_index;
  logic         char_found;
  logic [3:0]   finished;
  logic [8:0]   least1;
  logic [8:0]   least2;
  logic [9:0]   header;

  t05_cb_header_synth dut (
    .clk        (clk),
    .rst        (rst),
    .max_index  (max_index),
    .h_element  (h_element),
    .curr_index (curr_index),
    .curr_path  (curr_path),
    .curr_state (curr_state),
    .char_path  (char_path),
    .char_index (char_index),
    .char_found (char_found),
    .finished   (finished),
    .least1     (least1),
    .least2     (least2),
    .header     (header)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [70:0] tree [0:127];
  assign h_element = tree[curr_index];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] inode(input logic [6:0] idx);
    return {2'b10, idx};
  endfunction

  function automatic logic [8:0] leaf(input logic [7:0] c);
    return {1'b0, c};
  endfunction

  function automatic logic [70:0] node(input logic [8:0] l, input logic [8:0] r);
    return {7'd0, l, r, 46'd0};
  endfunction

  // Results of one walk
  logic [7:0]   got_char [16];
  logic [127:0] got_path [16];
  int           n_found;
  bit           walk_done;
  int           root_recs;
  logic [9:0]   root_hdr;
  logic [9:0]   first_hdr;

  task automatic run_walk(input int limit);
    bit         prev_found;
    logic [7:0] prev_char;
    n_found   = 0;
    walk_done = 1'b0;
    root_recs = 0;
    root_hdr  = 10'd0;
    first_hdr = 10'd0;
    prev_found = 1'b0;
    prev_char  = 8'd0;
    for (int cyc = 0; cyc < limit && !walk_done; cyc++) begin
      @(negedge clk);
      if (prev_found) begin
        check("hdr_char", {118'd0, header}, {118'd0, 2'b11, prev_char});
        if (n_found == 1) first_hdr = header;
      end else if (header[9:8] == 2'b10 && header[5:0] == 6'd0) begin
        root_recs++;
        root_hdr = header;
      end else begin
        check("hdr_idle", {118'd0, header}, 128'd0);
      end
      if (char_found) begin
        if (n_found < 16) begin
          got_char[n_found] = char_index;
          got_path[n_found] = char_path;
        end
        n_found++;
      end
      prev_found = char_found;
      prev_char  = char_index;
      if (finished == 4'd1) walk_done = 1'b1;
    end
    check("walk_finished", {127'd0, walk_done}, 128'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   {125'd0, curr_state}, 128'd5);
    check({tag, "_index"},   {121'd0, curr_index}, 128'd0);
    check({tag, "_path"},    curr_path, 128'd1);
    check({tag, "_cpath"},   char_path, 128'd1);
    check({tag, "_char"},    {120'd0, char_index}, 128'd0);
    check({tag, "_found"},   {127'd0, char_found}, 128'd0);
    check({tag, "_fin"},     {124'd0, finished}, 128'd0);
    check({tag, "_least"},   {110'd0, least1, least2}, 128'd0);
    check({tag, "_header"},  {118'd0, header}, 128'd0);
  endtask

  task automatic check_main_seq(input string tag);
    logic [7:0] exp_seq [10];
    exp_seq = '{8'd67, 8'd66, 8'd65, 8'd70, 8'd68, 8'd69, 8'd74, 8'd71, 8'd72, 8'd73};
    check({tag, "_nfound"}, n_found, 128'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_char%0d", tag, i), {120'd0, got_char[i]}, {120'd0, exp_seq[i]});
    check({tag, "_path_C"}, got_path[0], 128'h10);
    check({tag, "_path_B"}, got_path[1], 128'h18);
    check({tag, "_path_A"}, got_path[2], 128'hC);
    check({tag, "_path_J"}, got_path[6], 128'h5);
    check({tag, "_path_I"}, got_path[9], 128'h1F);
    check({tag, "_hdr_after_C"}, {118'd0, first_hdr}, {118'd0, 2'b11, 8'd67});
    check({tag, "_least1"}, {119'd0, least1}, 128'h106);
    check({tag, "_least2"}, {119'd0, least2}, 128'h107);
    check({tag, "_state_fin"}, {125'd0, curr_state}, 128'd4);
`ifdef T05_CB_HEADER_ROOT_EN
    check({tag, "_root_recs"}, root_recs, 128'd1);
    check({tag, "_root_hdr"}, {118'd0, root_hdr}, {118'd0, 10'b10_1_1_000000});
`else
    check({tag, "_root_recs"}, root_recs, 128'd0);
`endif
  endtask

  initial begin
    logic [6:0]   frz_index;
    logic [127:0] frz_path;
    logic [127:0] frz_cpath;
    bit           hit_track;

    for (int i = 0; i < 128; i++) tree[i] = 71'd0;
    tree[8] = node(inode(7'd6), inode(7'd7));
    tree[6] = node(inode(7'd3), inode(7'd4));
    tree[3] = node(inode(7'd0), leaf(8'd65));
    tree[0] = node(leaf(8'd67), leaf(8'd66));
    tree[4] = node(leaf(8'd70), inode(7'd1));
    tree[1] = node(leaf(8'd68), leaf(8'd69));
    tree[7] = node(leaf(8'd74), inode(7'd5));
    tree[5] = node(leaf(8'd71), inode(7'd2));
    tree[2] = node(leaf(8'd72), leaf(8'd73));
    max_index = 7'd8;

    // Reset values
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_reset_values("reset");

    // Full traversal of the test tree
    @(negedge clk) rst = 1'b1;
    run_walk(100);
    check_main_seq("walk1");

    // FINISH holds and freezes its registers
    frz_index = curr_index;
    frz_path  = curr_path;
    frz_cpath = char_path;
    repeat (5) @(negedge clk);
    check("freeze_index", {121'd0, curr_index}, {121'd0, frz_index});
    check("freeze_path",  curr_path, frz_path);
    check("freeze_cpath", char_path, frz_cpath);
    check("freeze_fin",   {124'd0, finished}, 128'd1);

    // Abort the walk in TRACK, then repeat the whole traversal
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    hit_track = 1'b0;
    for (int cyc = 0; cyc < 100 && !hit_track; cyc++) begin
      @(negedge clk);
      if (curr_state == 3'd2) hit_track = 1'b1;
    end
    check("track_reached", {127'd0, hit_track}, 128'd1);
    rst = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk) rst = 1'b1;
    run_walk(100);
    check_main_seq("walk2");

    // Single-node tree
    @(negedge clk) rst = 1'b0;
    tree[0]   = node(leaf(8'd88), leaf(8'd89));
    max_index = 7'd0;
    @(negedge clk) rst = 1'b1;
    run_walk(50);
    check("single_nfound", n_found, 128'd2);
    check("single_X", {120'd0, got_char[0]}, 128'd88);
    check("single_X_path", got_path[0], 128'h2);
    check("single_Y", {120'd0, got_char[1]}, 128'd89);
    check("single_Y_path", got_path[1], 128'h3);
    check("single_state", {125'd0, curr_state}, 128'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
